adc128s022_emulator: RTL and testbench

Synthesizable responder for the ADC128S022 serial interface: presents the ADC's pin-level behaviour to an SPI-style initiator clocked from the same FPGA clock. It oversamples ADC_SCLK, ADC_CS_N and ADC_SADDR on clk_in, decodes the 3-bit channel address, and shifts out 16-bit frames of four leading zeros followed by a 12-bit sample taken from a parallel channel bus. It sits in place of the physical ADC for bench and hardware-in-loop runs of the sensor reader, and drives ADC_SDAT back to the driver.

---
 rtl/adc128s022_emulator.sv | 231 +++++++++++++++++++++++
 tb/tb_adc128s022_emulator.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc128s022_emulator.sv
`timescale 1ns/1ps
// adc128s022_emulator
// Pin-level responder for the ADC128S022 serial interface. Oversamples
// ADC_SCLK/ADC_CS_N/ADC_SADDR on clk_in, decodes the 3-bit channel address
// from SCLK rising edges 3..5 and shifts out {4'b0, sample} MSB first on
// SCLK falling edges.
//
// Ports:
//   clk_in      system clock (rising edge)
//   reset       asynchronous active-high reset
//   ADC_SCLK    serial clock from initiator (idles high)
//   ADC_CS_N    active-low frame select
//   ADC_SADDR   serial address input, captured on SCLK rising edges
//   ch_data     8 x 12-bit channel samples, channel n at [12n+11:12n]
//   ADC_SDAT    serial data out, MSB first
//   sdat_oe     high while a frame is active
//   cur_addr    channel converted in the next frame
//   frame_done  one-cycle pulse on a complete frame
//   frame_err   one-cycle pulse on an early CS_N rise
//   frame_cnt   valid-frame counter (0 unless ADC_EMU_STATS_EN)
//   err_cnt     aborted-frame counter (0 unless ADC_EMU_STATS_EN)
//
// Optional feature macro: ADC_EMU_STATS_EN enables frame_cnt/err_cnt.
module adc128s022_emulator #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        ADC_SCLK,
    input  logic        ADC_CS_N,
    input  logic        ADC_SADDR,
    input  logic [95:0] ch_data,
    output logic        ADC_SDAT,
    output logic        sdat_oe,
    output logic [2:0]  cur_addr,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned SAMPLE_W   = 12;
    localparam int unsigned NUM_CH     = 8;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned PAD_W      = FRAME_BITS - SAMPLE_W;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int unsigned FLUSH      = SYNC_STAGES + 1;
    localparam int unsigned FLUSH_W    = $clog2(FLUSH + 1);
    // rise count seen before the edges carrying ADD2..ADD0 (edges 3..5)
    localparam int unsigned ADDR_FIRST = 2;
    localparam int unsigned ADDR_LAST  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_WAIT_HIGH
    } state_t;

    // Input synchronizers plus one delay flop for edge detection
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_saddr_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sclk_sync  <= '1;
            r_cs_sync    <= '1;
            r_saddr_sync <= '0;
            r_sclk_d     <= 1'b1;
            r_cs_d       <= 1'b1;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
            r_saddr_sync <= {r_saddr_sync[SYNC_STAGES-2:0], ADC_SADDR};
            r_sclk_d     <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d       <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk, w_cs, w_saddr;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_saddr     = r_saddr_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;

    // Frame state
    state_t                r_state,    w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift,    w_shift_nxt;
    logic [ADDR_W-1:0]     r_din,      w_din_nxt;
    logic [CNT_W-1:0]      r_rise_cnt, w_rise_cnt_nxt;
    logic [ADDR_W-1:0]     r_cur_addr, w_cur_addr_nxt;
    logic                  r_oe,       w_oe_nxt;
    logic                  r_done,     w_done_nxt;
    logic                  r_err,      w_err_nxt;
    logic [FLUSH_W-1:0]    r_flush,    w_flush_nxt;
    logic [SAMPLE_W-1:0]   w_sample;

    // Sample of the currently addressed channel
    always_comb begin
        w_sample = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_cur_addr == ADDR_W'(i)) begin
                w_sample = ch_data[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // State and datapath registers; reset parks in WAIT_HIGH until the
    // synchronizers have flushed so a CS_N held low is not seen as a fall
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= S_WAIT_HIGH;
            r_shift    <= '0;
            r_din      <= '0;
            r_rise_cnt <= '0;
            r_cur_addr <= '0;
            r_oe       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_flush    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_din      <= w_din_nxt;
            r_rise_cnt <= w_rise_cnt_nxt;
            r_cur_addr <= w_cur_addr_nxt;
            r_oe       <= w_oe_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_flush    <= w_flush_nxt;
        end
    end

    // Next-state logic; CS_N rise outranks any SCLK edge in the same cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_din_nxt      = r_din;
        w_rise_cnt_nxt = r_rise_cnt;
        w_cur_addr_nxt = r_cur_addr;
        w_oe_nxt       = r_oe;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_flush_nxt    = (r_flush < FLUSH_W'(FLUSH)) ? r_flush + FLUSH_W'(1) : r_flush;

        case (r_state)
            S_WAIT_HIGH: begin
                if ((r_flush == FLUSH_W'(FLUSH)) && w_cs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_shift_nxt    = {PAD_W'(0), w_sample};
                    w_din_nxt      = '0;
                    w_rise_cnt_nxt = '0;
                    w_oe_nxt       = 1'b1;
                    w_state_nxt    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    if (r_rise_cnt == CNT_W'(FRAME_BITS)) begin
                        w_done_nxt     = 1'b1;
                        w_cur_addr_nxt = r_din;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_oe_nxt    = 1'b0;
                    w_shift_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (w_sclk_rise) begin
                    if (r_rise_cnt < CNT_W'(FRAME_BITS)) begin
                        // only edges 3..5 carry the address
                        if ((r_rise_cnt >= CNT_W'(ADDR_FIRST)) &&
                            (r_rise_cnt <= CNT_W'(ADDR_LAST))) begin
                            w_din_nxt = {r_din[ADDR_W-2:0], w_saddr};
                        end
                        w_rise_cnt_nxt = r_rise_cnt + CNT_W'(1);
                    end
                end else if (w_sclk_fall) begin
                    w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ADC_SDAT   = r_shift[FRAME_BITS-1];
    assign sdat_oe    = r_oe;
    assign cur_addr   = r_cur_addr;
    assign frame_done = r_done;
    assign frame_err  = r_err;

`ifdef ADC_EMU_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;

    // Counters move in the same cycle as their pulse
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_done_nxt) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err_nxt) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_adc128s022_emulator.sv
`timescale 1ns/1ps
// Bench for adc128s022_emulator: acts as the SPI initiator, keeps an
// event-level model of the ADC frame and compares every output every cycle.
module tb_adc128s022_emulator;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FRAME_BITS  = 16;
    localparam int unsigned LAT         = SYNC_STAGES + 1;

`ifdef ADC_EMU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset;
    logic        ADC_SCLK;
    logic        ADC_CS_N;
    logic        ADC_SADDR;
    logic [95:0] ch_data;
    logic        ADC_SDAT;
    logic        sdat_oe;
    logic [2:0]  cur_addr;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    adc128s022_emulator #(
        .SYNC_STAGES(SYNC_STAGES),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .ADC_SCLK  (ADC_SCLK),
        .ADC_CS_N  (ADC_CS_N),
        .ADC_SADDR (ADC_SADDR),
        .ch_data   (ch_data),
        .ADC_SDAT  (ADC_SDAT),
        .sdat_oe   (sdat_oe),
        .cur_addr  (cur_addr),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        sdat;
        logic        oe;
        logic [2:0]  addr;
        logic        done;
        logic        err;
        logic [15:0] fcnt;
        logic [7:0]  ecnt;
    } obs_t;

    typedef struct {
        int unsigned cyc;
        obs_t        v;
    } sched_t;

    sched_t      q[$];
    obs_t        m_exp;
    int unsigned cyc;
    int          n_vec;
    int          n_err;
    int          n_done_seen;
    int          n_err_seen;

    // Transaction-level model state
    bit          m_active;
    logic [15:0] m_word;
    int          m_falls;
    int          m_rises;
    logic [2:0]  m_addr_bits;
    logic [2:0]  m_cur;
    logic [15:0] m_fcnt;
    logic [7:0]  m_ecnt;
    logic        m_sdat;
    logic        m_oe;

    function automatic obs_t dut_obs();
        return obs_t'({ADC_SDAT, sdat_oe, cur_addr, frame_done, frame_err, frame_cnt, err_cnt});
    endfunction

    function automatic obs_t snap(input logic d, input logic e);
        return obs_t'({m_sdat, m_oe, m_cur, d, e, m_fcnt, m_ecnt});
    endfunction

    task automatic sched(input obs_t v);
        sched_t s;
        s.cyc = cyc + LAT;
        s.v   = v;
        q.push_back(s);
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_word      = '0;
        m_falls     = 0;
        m_rises     = 0;
        m_addr_bits = '0;
        m_cur       = '0;
        m_fcnt      = '0;
        m_ecnt      = '0;
        m_sdat      = 1'b0;
        m_oe        = 1'b0;
        q.delete();
        m_exp = snap(1'b0, 1'b0);
    endtask

    task automatic m_cs_low();
        if (!m_active) begin
            m_active    = 1'b1;
            m_word      = {4'b0, ch_data[int'(m_cur)*12 +: 12]};
            m_falls     = 0;
            m_rises     = 0;
            m_addr_bits = '0;
            m_oe        = 1'b1;
            m_sdat      = m_word[15];
            sched(snap(1'b0, 1'b0));
        end
    endtask

    task automatic m_fall();
        if (m_active) begin
            m_falls++;
            m_sdat = (m_falls < 16) ? m_word[15 - m_falls] : 1'b0;
            sched(snap(1'b0, 1'b0));
        end
    endtask

    task automatic m_rise(input logic b);
        if (m_active && m_rises < 16) begin
            m_rises++;
            if (m_rises == 3) m_addr_bits[2] = b;
            if (m_rises == 4) m_addr_bits[1] = b;
            if (m_rises == 5) m_addr_bits[0] = b;
        end
    endtask

    task automatic m_cs_high();
        if (m_active) begin
            m_active = 1'b0;
            m_oe     = 1'b0;
            m_sdat   = 1'b0;
            if (m_rises == 16) begin
                m_cur = m_addr_bits;
                if (STATS) m_fcnt = m_fcnt + 16'd1;
                sched(snap(1'b1, 1'b0));
            end else begin
                if (STATS) m_ecnt = m_ecnt + 8'd1;
                sched(snap(1'b0, 1'b1));
            end
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    task automatic compare_cycle();
        obs_t act;
        m_exp.done = 1'b0;
        m_exp.err  = 1'b0;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            m_exp = q[0].v;
            void'(q.pop_front());
        end
        act = dut_obs();
        n_vec++;
        if (act !== m_exp) begin
            n_err++;
            $display("FAIL cycle %0d outputs: got sdat=%b oe=%b addr=%0d done=%b err=%b fcnt=%0d ecnt=%0d, expected sdat=%b oe=%b addr=%0d done=%b err=%b fcnt=%0d ecnt=%0d",
                     cyc, act.sdat, act.oe, act.addr, act.done, act.err, act.fcnt, act.ecnt,
                     m_exp.sdat, m_exp.oe, m_exp.addr, m_exp.done, m_exp.err, m_exp.fcnt, m_exp.ecnt);
        end
        if (frame_done === 1'b1) n_done_seen++;
        if (frame_err === 1'b1) n_err_seen++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_in);
            compare_cycle();
            @(posedge clk_in);
            cyc++;
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_reset();
        step(n);
        reset = 1'b0;
    endtask

    // One initiator frame: nrise SCLK cycles, ADC_SDAT sampled before each fall
    task automatic frame(input int nrise, input logic [2:0] addr, input int h,
                         input int chg_at, input logic [11:0] chg_val,
                         input int rst_at, output logic [31:0] rx);
        logic b;
        rx = '0;
        ADC_CS_N = 1'b0;
        m_cs_low();
        step(h);
        for (int i = 1; i <= nrise; i++) begin
            rx = {rx[30:0], ADC_SDAT};
            b = (i == 3) ? addr[2] : (i == 4) ? addr[1] : (i == 5) ? addr[0] : 1'($urandom);
            ADC_SCLK  = 1'b0;
            ADC_SADDR = b;
            m_fall();
            step(h);
            ADC_SCLK = 1'b1;
            m_rise(b);
            step(h);
            if (i == chg_at) ch_data[int'(m_cur)*12 +: 12] = chg_val;
            if (i == rst_at) begin
                do_reset(5);
                return;
            end
        end
        ADC_CS_N = 1'b1;
        m_cs_high();
        step(h + 2);
    endtask

    logic [31:0] rx;
    int          d0;
    int          e0;

    initial begin
        n_vec = 0; n_err = 0; n_done_seen = 0; n_err_seen = 0; cyc = 0;
        ADC_SCLK = 1'b1; ADC_CS_N = 1'b1; ADC_SADDR = 1'b0; ch_data = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk_in);
        #1;
        step(4);
        check("reset_state", 32'(dut_obs()), 32'h0);
        reset = 1'b0;
        step(10);
        check("idle_after_reset", 32'(dut_obs()), 32'h0);

        ch_data = {$urandom, $urandom, $urandom};
        ch_data[0*12 +: 12] = 12'h123;
        ch_data[2*12 +: 12] = 12'h5A5;
        ch_data[3*12 +: 12] = 12'hABC;

        d0 = n_done_seen;
        frame(16, 3'd3, 17, 0, 12'h0, 0, rx);
        check("frame1_data", 32'(rx[15:0]), 32'h0123);
        check("frame1_addr", 32'(cur_addr), 32'd3);
        check("frame1_done_pulses", 32'(n_done_seen - d0), 32'd1);

        frame(16, 3'd0, 6, 0, 12'h0, 0, rx);
        check("frame2_data", 32'(rx[15:0]), 32'h0ABC);

        e0 = n_err_seen;
        frame(8, 3'd5, 5, 0, 12'h0, 0, rx);
        check("abort_addr_kept", 32'(cur_addr), 32'd0);
        check("abort_err_pulses", 32'(n_err_seen - e0), 32'd1);
        frame(16, 3'd2, 7, 0, 12'h0, 0, rx);
        check("after_abort_data", 32'(rx[15:0]), 32'h0123);

        frame(20, 3'd6, 5, 0, 12'h0, 0, rx);
        check("long_frame_bits", 32'(rx[19:0]), 32'h05A50);
        check("long_frame_addr", 32'(cur_addr), 32'd6);

        ch_data[6*12 +: 12] = 12'h123;
        frame(16, 3'd0, 6, 6, 12'h456, 0, rx);
        check("midframe_change", 32'(rx[15:0]), 32'h0123);

        frame(16, 3'd4, 6, 0, 12'h0, 5, rx);
        step(20);
        check("held_low_oe", 32'(sdat_oe), 32'd0);
        check("held_low_addr", 32'(cur_addr), 32'd0);
        ADC_CS_N = 1'b1;
        m_cs_high();
        step(10);
        frame(16, 3'd1, 5, 0, 12'h0, 0, rx);
        check("post_reset_ch0", 32'(rx[15:0]), 32'h0123);
        check("post_reset_addr", 32'(cur_addr), 32'd1);

        frame(16, 3'd2, 5, 0, 12'h0, 0, rx);
        frame(3, 3'd7, 5, 0, 12'h0, 0, rx);
        frame(16, 3'd4, 5, 0, 12'h0, 0, rx);
        frame(0, 3'd1, 5, 0, 12'h0, 0, rx);
        check("stats_frame_cnt", 32'(frame_cnt), STATS ? 32'd3 : 32'd0);
        check("stats_err_cnt", 32'(err_cnt), STATS ? 32'd2 : 32'd0);

        for (int k = 0; k < 30; k++) begin
            ch_data = {$urandom, $urandom, $urandom};
            frame(int'($urandom_range(0, 22)), 3'($urandom), int'($urandom_range(5, 9)),
                  int'($urandom_range(0, 16)), 12'($urandom), 0, rx);
            step(int'($urandom_range(0, 5)));
        end

        step(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
